segdisplay_scan: RTL and testbench

//  Parametrised N-digit multiplexed 7-segment driver, successor to the 2-digit segdisplay.

---
 rtl/seg_pkg.sv | 23 ++
 rtl/digits_to_segments.sv | 11 +
 rtl/segdisplay_scan.sv | 150 +++++++++++++++
 tb/tb_segdisplay_scan.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan driver.
package seg_pkg;

    // All segments dark (segments are active-low).
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Hex nibble to active-low {g,f,e,d,c,b,a} pattern.
    localparam logic [6:0] HEX_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Bits needed to index n items; never less than 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/digits_to_segments.sv
// Hex nibble to active-low 7-segment pattern decoder.
module digits_to_segments
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segPattern_c
);

    assign segPattern_c = HEX_TABLE[nibble];

endmodule

// File: rtl/segdisplay_scan.sv
// N-digit multiplexed 7-segment scanner with double-buffered loads,
// per-digit blanking/dp, leading-zero suppression, PWM dimming and
// anti-ghost blanking after every digit switch.
module segdisplay_scan
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 2,
    parameter bit          DIGIT_ACT_LOW = 1'b0,
    parameter bit          LZ_SUPPRESS   = 1'b0,
    parameter int unsigned GHOST_CYC     = 4,
    parameter int unsigned PWM_BITS      = 4
) (
    input  logic                    refclk,
    input  logic                    reset,
    input  logic                    mSFlag,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic [6:0]              segPins,
    output logic                    dpPin,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int unsigned IDX_W   = clog2(NUM_DIGITS);
    localparam int unsigned VAL_W   = 4 * NUM_DIGITS;
    localparam int unsigned GHOST_W = clog2(GHOST_CYC + 1);

    localparam logic [NUM_DIGITS-1:0] SEL_ONE   = NUM_DIGITS'(1);
    localparam logic [NUM_DIGITS-1:0] SEL_RESET = DIGIT_ACT_LOW ? ~SEL_ONE : SEL_ONE;

    logic [IDX_W-1:0]      idx, idxNext;
    logic [GHOST_W-1:0]    ghostCnt, ghostNext;
    logic [PWM_BITS-1:0]   pwmCnt;

    logic [VAL_W-1:0]      shadowVal, dispVal, dispValNext;
    logic [NUM_DIGITS-1:0] shadowDp, dispDp, dispDpNext;
    logic [NUM_DIGITS-1:0] shadowBlank, dispBlank, dispBlankNext;

    logic                  wrap;
    logic [3:0]            nibble;
    logic                  selDp;
    logic                  selBlank;
    logic                  selLz;
    logic                  pwmOn;
    logic                  dark;
    logic [NUM_DIGITS-1:0] selNext;
    logic [NUM_DIGITS-1:0] lzDark;
    logic                  allZero;
    logic [6:0]            decoded;

    // Scan index, commit-on-wrap and ghost counter next state.
    always_comb begin
        idxNext       = idx;
        ghostNext     = ghostCnt;
        dispValNext   = dispVal;
        dispDpNext    = dispDp;
        dispBlankNext = dispBlank;
        wrap          = mSFlag && (idx == IDX_W'(NUM_DIGITS - 1));

        if (mSFlag) begin
            idxNext = wrap ? '0 : idx + 1'b1;
        end

        // Commit only at frame boundary so one frame never mixes old and new data.
        if (wrap) begin
            dispValNext   = shadowVal;
            dispDpNext    = shadowDp;
            dispBlankNext = shadowBlank;
        end

        if (mSFlag) begin
            ghostNext = GHOST_W'(GHOST_CYC);
        end else if (ghostCnt != '0) begin
            ghostNext = ghostCnt - 1'b1;
        end
    end

    // Leading-zero mask over the (about to be) committed digits; blanked digits stop the run.
    always_comb begin
        lzDark  = '0;
        allZero = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
            allZero   = allZero && (dispValNext[4*i +: 4] == 4'h0) && !dispBlankNext[i];
            lzDark[i] = LZ_SUPPRESS && allZero;
        end
    end

    // Per-digit field mux, dark decision and digit enable for the digit shown next cycle.
    always_comb begin
        nibble   = '0;
        selDp    = 1'b0;
        selBlank = 1'b0;
        selLz    = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idxNext == IDX_W'(i)) begin
                nibble   = dispValNext[4*i +: 4];
                selDp    = dispDpNext[i];
                selBlank = dispBlankNext[i];
                selLz    = lzDark[i];
            end
        end
        pwmOn   = (brightness == '1) || (pwmCnt < brightness);
        dark    = (ghostNext != '0) || !pwmOn || selBlank || selLz;
        selNext = DIGIT_ACT_LOW ? ~(SEL_ONE << idxNext) : (SEL_ONE << idxNext);
    end

    digits_to_segments u_decode (
        .nibble       (nibble),
        .segPattern_c (decoded)
    );

    // State and registered pin drivers.
    always_ff @(posedge refclk) begin
        if (reset) begin
            idx         <= '0;
            ghostCnt    <= GHOST_W'(GHOST_CYC);
            pwmCnt      <= '0;
            shadowVal   <= '0;
            shadowDp    <= '0;
            shadowBlank <= '0;
            dispVal     <= '0;
            dispDp      <= '0;
            dispBlank   <= '0;
            segPins     <= SEG_OFF;
            dpPin       <= 1'b1;
            digit_sel   <= SEL_RESET;
            frame_done  <= 1'b0;
        end else begin
            idx       <= idxNext;
            ghostCnt  <= ghostNext;
            pwmCnt    <= pwmCnt + 1'b1;
            dispVal   <= dispValNext;
            dispDp    <= dispDpNext;
            dispBlank <= dispBlankNext;
            if (load) begin
                shadowVal   <= value;
                shadowDp    <= dp;
                shadowBlank <= blank;
            end
            segPins    <= dark ? SEG_OFF : decoded;
            dpPin      <= dark || !selDp;
            digit_sel  <= selNext;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_segdisplay_scan.sv
// Self-checking bench for segdisplay_scan: 4 digits, one instance without and
// one with leading-zero suppression, driven in lockstep from shared inputs.
module tb_segdisplay_scan;

    localparam int unsigned ND    = 4;
    localparam int          GHOST = 4;

    localparam logic [6:0] HEX_REF [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        refclk = 1'b0;
    logic        reset;
    logic        mSFlag;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  brightness;

    logic [6:0]  segPinsA, segPinsB;
    logic        dpPinA, dpPinB;
    logic [3:0]  selA, selB;
    logic        fdA, fdB;

    int checks = 0;
    int errors = 0;

    // Scoreboards: {frame_done, digit_sel, segPins, dpPin} expected after each scan step.
    logic [12:0] sbA [$];
    logic [12:0] sbB [$];

    // Reference model state.
    int          mIdx;
    logic [15:0] mShadowVal, mShownVal;
    logic [3:0]  mShadowDp, mShownDp, mShadowBlank, mShownBlank;

    always #5 refclk = ~refclk;

    segdisplay_scan #(
        .NUM_DIGITS(ND), .DIGIT_ACT_LOW(1'b0), .LZ_SUPPRESS(1'b0),
        .GHOST_CYC(GHOST), .PWM_BITS(4)
    ) dutA (
        .refclk(refclk), .reset(reset), .mSFlag(mSFlag), .load(load),
        .value(value), .dp(dp), .blank(blank), .brightness(brightness),
        .segPins(segPinsA), .dpPin(dpPinA), .digit_sel(selA), .frame_done(fdA)
    );

    segdisplay_scan #(
        .NUM_DIGITS(ND), .DIGIT_ACT_LOW(1'b0), .LZ_SUPPRESS(1'b1),
        .GHOST_CYC(GHOST), .PWM_BITS(4)
    ) dutB (
        .refclk(refclk), .reset(reset), .mSFlag(mSFlag), .load(load),
        .value(value), .dp(dp), .blank(blank), .brightness(brightness),
        .segPins(segPinsB), .dpPin(dpPinB), .digit_sel(selB), .frame_done(fdB)
    );

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic modelReset();
        mIdx         = 0;
        mShadowVal   = '0; mShownVal   = '0;
        mShadowDp    = '0; mShownDp    = '0;
        mShadowBlank = '0; mShownBlank = '0;
    endtask

    // Expected {digit_sel, segPins, dpPin} for digit idx from the committed model data.
    function automatic logic [11:0] expOut(input int idx, input bit lz);
        logic [3:0] nib;
        logic [3:0] sel;
        logic       dark;
        logic       allZero;
        nib  = mShownVal[idx*4 +: 4];
        dark = mShownBlank[idx];
        if (lz && idx > 0) begin
            allZero = 1'b1;
            for (int j = idx; j < 4; j++) begin
                if (mShownVal[j*4 +: 4] != 4'h0 || mShownBlank[j]) allZero = 1'b0;
            end
            if (allZero) dark = 1'b1;
        end
        sel = 4'b0001 << idx;
        return dark ? {sel, 7'h7F, 1'b1} : {sel, HEX_REF[nib], ~mShownDp[idx]};
    endfunction

    task automatic doLoad(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        value = v; dp = d; blank = b; load = 1'b1;
        tick();
        load = 1'b0;
        mShadowVal = v; mShadowDp = d; mShadowBlank = b;
    endtask

    // One mSFlag pulse (optionally with a simultaneous load); pushes the expected
    // result, observes the anti-ghost window, and returns with outputs settled.
    task automatic scanStep(input bit withLoad, input logic [15:0] v, input logic [3:0] d,
                            input logic [3:0] b, output int ghostOff, output logic [2:0] fdObs);
        bit wrap;
        logic stray;
        mSFlag = 1'b1;
        if (withLoad) begin
            value = v; dp = d; blank = b; load = 1'b1;
        end
        wrap = (mIdx == 3);
        if (wrap) begin
            mIdx = 0;
            mShownVal = mShadowVal; mShownDp = mShadowDp; mShownBlank = mShadowBlank;
        end else begin
            mIdx++;
        end
        if (withLoad) begin
            mShadowVal = v; mShadowDp = d; mShadowBlank = b;
        end
        sbA.push_back({wrap, expOut(mIdx, 1'b0)});
        sbB.push_back({wrap, expOut(mIdx, 1'b1)});
        tick();
        mSFlag = 1'b0;
        load   = 1'b0;
        stray    = 1'b0;
        ghostOff = 0;
        fdObs    = {1'b0, fdB, fdA};
        for (int k = 0; k < GHOST; k++) begin
            if (k > 0) begin
                tick();
                if (fdA || fdB) stray = 1'b1;
            end
            if (segPinsA == 7'h7F && dpPinA) ghostOff++;
        end
        tick();
        if (fdA || fdB) stray = 1'b1;
        fdObs[2] = stray;
    endtask

    task automatic test_reset();
        reset = 1'b1; mSFlag = 1'b0; load = 1'b0;
        value = '0; dp = '0; blank = '0; brightness = 4'hF;
        repeat (3) tick();
        checks++; if (segPinsA !== 7'h7F) begin errors++; $display("FAIL reset segPins got %h want 7f", segPinsA); end
        checks++; if (dpPinA !== 1'b1) begin errors++; $display("FAIL reset dpPin got %b want 1", dpPinA); end
        checks++; if (selA !== 4'b0001) begin errors++; $display("FAIL reset digit_sel got %b want 0001", selA); end
        checks++; if (fdA !== 1'b0) begin errors++; $display("FAIL reset frame_done got %b want 0", fdA); end
        checks++; if (segPinsB !== 7'h7F) begin errors++; $display("FAIL reset segPinsB got %h want 7f", segPinsB); end
        reset = 1'b0;
        modelReset();
        repeat (3) tick();
        checks++; if (segPinsA !== 7'h7F) begin errors++; $display("FAIL post-reset ghost segPins got %h want 7f", segPinsA); end
        tick();
        checks++; if ({selA, segPinsA, dpPinA} !== {4'b0001, 7'h40, 1'b1}) begin
            errors++; $display("FAIL post-reset digit0 got %h want %h", {selA, segPinsA, dpPinA}, {4'b0001, 7'h40, 1'b1});
        end
    endtask

    // Load 12AF, run to commit, then a full frame: F, A, 2, 1 and back to digit 0.
    task automatic test_scan_frame();
        logic [12:0] eA, eB;
        logic [2:0]  fd;
        int          gOff;
        int          fdCount;
        fdCount = 0;
        doLoad(16'h12AF, 4'h0, 4'h0);
        for (int s = 0; s < 8; s++) begin
            scanStep(1'b0, 16'h0, 4'h0, 4'h0, gOff, fd);
            eA = sbA.pop_front(); eB = sbB.pop_front();
            if (s >= 4 && fd[0]) fdCount++;
            checks++; if ({selA, segPinsA, dpPinA} !== eA[11:0]) begin errors++; $display("FAIL scan s%0d A got %h want %h", s, {selA, segPinsA, dpPinA}, eA[11:0]); end
            checks++; if ({selB, segPinsB, dpPinB} !== eB[11:0]) begin errors++; $display("FAIL scan s%0d B got %h want %h", s, {selB, segPinsB, dpPinB}, eB[11:0]); end
            checks++; if (fd !== {1'b0, eA[12], eA[12]}) begin errors++; $display("FAIL scan s%0d frame_done got %b want %b", s, fd, {1'b0, eA[12], eA[12]}); end
            checks++; if (gOff != GHOST) begin errors++; $display("FAIL scan s%0d ghost cycles got %0d want %0d", s, gOff, GHOST); end
        end
        checks++; if (fdCount != 1) begin errors++; $display("FAIL scan frame_done pulses got %0d want 1", fdCount); end
    endtask

    // New data loaded at index 2 must not appear until the next wrap.
    task automatic test_midframe_load();
        logic [12:0] eA, eB;
        logic [2:0]  fd;
        int          gOff;
        int          n;
        for (int s = 0; s < 4 && mIdx != 2; s++) begin
            scanStep(1'b0, 16'h0, 4'h0, 4'h0, gOff, fd);
            eA = sbA.pop_front(); eB = sbB.pop_front();
            checks++; if ({selA, segPinsA, dpPinA} !== eA[11:0]) begin errors++; $display("FAIL midload pre s%0d got %h want %h", s, {selA, segPinsA, dpPinA}, eA[11:0]); end
        end
        doLoad(16'h0000, 4'h0, 4'h0);
        n = (4 - mIdx) + 4;
        for (int s = 0; s < n; s++) begin
            scanStep(1'b0, 16'h0, 4'h0, 4'h0, gOff, fd);
            eA = sbA.pop_front(); eB = sbB.pop_front();
            checks++; if ({selA, segPinsA, dpPinA} !== eA[11:0]) begin errors++; $display("FAIL midload s%0d got %h want %h", s, {selA, segPinsA, dpPinA}, eA[11:0]); end
            checks++; if (fd !== {1'b0, eA[12], eA[12]}) begin errors++; $display("FAIL midload s%0d frame_done got %b want %b", s, fd, {1'b0, eA[12], eA[12]}); end
        end
    endtask

    // Load coinciding with the wrap: commit takes the old shadow, new data shows a frame later.
    task automatic test_load_at_wrap();
        logic [12:0] eA, eB;
        logic [2:0]  fd;
        int          gOff;
        for (int s = 0; s < 4 && mIdx != 3; s++) begin
            scanStep(1'b0, 16'h0, 4'h0, 4'h0, gOff, fd);
            eA = sbA.pop_front(); eB = sbB.pop_front();
            checks++; if ({selA, segPinsA, dpPinA} !== eA[11:0]) begin errors++; $display("FAIL wrapload pre s%0d got %h want %h", s, {selA, segPinsA, dpPinA}, eA[11:0]); end
        end
        for (int s = 0; s < 6; s++) begin
            scanStep(s == 0, 16'h3456, 4'h0, 4'h0, gOff, fd);
            eA = sbA.pop_front(); eB = sbB.pop_front();
            checks++; if ({selA, segPinsA, dpPinA} !== eA[11:0]) begin errors++; $display("FAIL wrapload s%0d got %h want %h", s, {selA, segPinsA, dpPinA}, eA[11:0]); end
            checks++; if (fd !== {1'b0, eA[12], eA[12]}) begin errors++; $display("FAIL wrapload s%0d frame_done got %b want %b", s, fd, {1'b0, eA[12], eA[12]}); end
        end
    endtask

    // Decimal point only on digit 1; digit 3 fully dark including dp.
    task automatic test_dp_blank();
        logic [12:0] eA, eB;
        logic [2:0]  fd;
        int          gOff;
        int          n;
        doLoad(16'h89CD, 4'b0010, 4'b1000);
        n = (4 - mIdx) + 4;
        for (int s = 0; s < n; s++) begin
            scanStep(1'b0, 16'h0, 4'h0, 4'h0, gOff, fd);
            eA = sbA.pop_front(); eB = sbB.pop_front();
            checks++; if ({selA, segPinsA, dpPinA} !== eA[11:0]) begin errors++; $display("FAIL dpblank s%0d got %h want %h", s, {selA, segPinsA, dpPinA}, eA[11:0]); end
        end
    endtask

    // Leading-zero suppression on instance B, including a blanked top digit.
    task automatic test_lz();
        logic [12:0] eA, eB;
        logic [2:0]  fd;
        int          gOff;
        int          n;
        logic [15:0] vals   [3];
        logic [3:0]  blanks [3];
        vals[0] = 16'h0050; blanks[0] = 4'b0000;
        vals[1] = 16'h0000; blanks[1] = 4'b0000;
        vals[2] = 16'h0050; blanks[2] = 4'b1000;
        for (int t = 0; t < 3; t++) begin
            doLoad(vals[t], 4'h0, blanks[t]);
            n = (4 - mIdx) + 4;
            for (int s = 0; s < n; s++) begin
                scanStep(1'b0, 16'h0, 4'h0, 4'h0, gOff, fd);
                eA = sbA.pop_front(); eB = sbB.pop_front();
                checks++; if ({selB, segPinsB, dpPinB} !== eB[11:0]) begin errors++; $display("FAIL lz t%0d s%0d B got %h want %h", t, s, {selB, segPinsB, dpPinB}, eB[11:0]); end
                checks++; if ({selA, segPinsA, dpPinA} !== eA[11:0]) begin errors++; $display("FAIL lz t%0d s%0d A got %h want %h", t, s, {selA, segPinsA, dpPinA}, eA[11:0]); end
            end
        end
    endtask

    // Lit duty over two full PWM periods for several brightness settings.
    task automatic test_pwm();
        logic [3:0] levels [4];
        int         want   [4];
        int         lit;
        levels[0] = 4'd8;  want[0] = 16;
        levels[1] = 4'd0;  want[1] = 0;
        levels[2] = 4'd15; want[2] = 32;
        levels[3] = 4'd1;  want[3] = 2;
        for (int t = 0; t < 4; t++) begin
            brightness = levels[t];
            tick();
            lit = 0;
            for (int c = 0; c < 32; c++) begin
                tick();
                if (segPinsA != 7'h7F) lit++;
            end
            checks++; if (lit != want[t]) begin errors++; $display("FAIL pwm brightness=%0d lit got %0d want %0d", levels[t], lit, want[t]); end
        end
        brightness = 4'hF;
    endtask

    // Reset at index 2 abandons the frame and the pending shadow.
    task automatic test_reset_midframe();
        logic [12:0] eA, eB;
        logic [2:0]  fd;
        int          gOff;
        doLoad(16'hBEEF, 4'hF, 4'h0);
        for (int s = 0; s < 4 && mIdx != 2; s++) begin
            scanStep(1'b0, 16'h0, 4'h0, 4'h0, gOff, fd);
            eA = sbA.pop_front(); eB = sbB.pop_front();
            checks++; if ({selA, segPinsA, dpPinA} !== eA[11:0]) begin errors++; $display("FAIL rstmid pre s%0d got %h want %h", s, {selA, segPinsA, dpPinA}, eA[11:0]); end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        modelReset();
        checks++; if ({selA, segPinsA, dpPinA, fdA} !== {4'b0001, 7'h7F, 1'b1, 1'b0}) begin
            errors++; $display("FAIL rstmid state got %h want %h", {selA, segPinsA, dpPinA, fdA}, {4'b0001, 7'h7F, 1'b1, 1'b0});
        end
        repeat (4) tick();
        checks++; if ({selA, segPinsA, dpPinA} !== {4'b0001, 7'h40, 1'b1}) begin
            errors++; $display("FAIL rstmid cleared digit0 got %h want %h", {selA, segPinsA, dpPinA}, {4'b0001, 7'h40, 1'b1});
        end
        for (int s = 0; s < 8; s++) begin
            scanStep(1'b0, 16'h0, 4'h0, 4'h0, gOff, fd);
            eA = sbA.pop_front(); eB = sbB.pop_front();
            checks++; if ({selA, segPinsA, dpPinA} !== eA[11:0]) begin errors++; $display("FAIL rstmid s%0d got %h want %h", s, {selA, segPinsA, dpPinA}, eA[11:0]); end
            checks++; if (fd !== {1'b0, eA[12], eA[12]}) begin errors++; $display("FAIL rstmid s%0d frame_done got %b want %b", s, fd, {1'b0, eA[12], eA[12]}); end
        end
    endtask

    initial begin
        test_reset();
        test_scan_frame();
        test_midframe_load();
        test_load_at_wrap();
        test_dp_blank();
        test_lz();
        test_pwm();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1);
    end

endmodule
